// File: rtl/bch_decoder_15_5_if.sv
// -----------------------------------------------------------------------------
// bch_decoder_15_5_if
// Request/result bundle between the receive path (master) and the BCH(15,5)
// decoder (slave).
//   start         master->slave  decode request, sampled only while idle
//   rx_word[14:0] master->slave  received word, [14:10] data, [9:0] parity
//   data_out[4:0] slave->master  corrected data (raw data if uncorrectable)
//   codeword_out  slave->master  corrected 15-bit codeword
//   err_count     slave->master  number of bits corrected (0..3)
//   uncorrectable slave->master  nonzero syndrome that no rotation trapped
//   busy          slave->master  decode in progress
//   done          slave->master  one-cycle pulse, results valid from here on
// -----------------------------------------------------------------------------
interface bch_decoder_15_5_if;
  logic        start;
  logic [14:0] rx_word;
  logic [4:0]  data_out;
  logic [14:0] codeword_out;
  logic [1:0]  err_count;
  logic        uncorrectable;
  logic        busy;
  logic        done;

  modport master (
    output start, rx_word,
    input  data_out, codeword_out, err_count, uncorrectable, busy, done
  );

  modport slave (
    input  start, rx_word,
    output data_out, codeword_out, err_count, uncorrectable, busy, done
  );
endinterface

// File: rtl/bch_decoder_15_5.sv
// -----------------------------------------------------------------------------
// bch_decoder_15_5
// Serial BCH(15,5) decoder, g(x) = x^10+x^8+x^5+x^4+x^2+x+1.
// A received word is latched on start, its syndrome is computed bit-serially
// (15 cycles, MSB first), then the word and syndrome are rotated together for
// 15 cycles; the first rotation whose syndrome weight is <= TRAP_WT has its
// error pattern sitting entirely in the parity bits, so it is XORed away.
// After 15 rotations the word is back in its original alignment.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any decode, clears outputs)
//   bus    bch_decoder_15_5_if.slave (start/rx_word in, results/busy/done out)
//
// Parameter:
//   TRAP_WT  maximum syndrome weight accepted as a trapped pattern, 1..3
//
// Build option:
//   BCH_DEC_EARLY_EXIT_EN  when defined, a zero syndrome after the SYN phase
//                          skips the trapping phase (done after 16 cycles
//                          instead of 31).
// -----------------------------------------------------------------------------
module bch_decoder_15_5 #(
  parameter int TRAP_WT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bch_decoder_15_5_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYN,
    S_TRAP,
    S_DONE
  } state_t;

  // Low-order taps of g(x); x^10 is implicit in the shift.
  localparam logic [9:0] G          = 10'h137;
  localparam logic [3:0] TRAP_WT_L  = 4'(TRAP_WT);

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  state_t      state_q;
  logic [9:0]  s_q;
  logic [14:0] w_q;
  logic [3:0]  cnt_q;
  logic        trapped_q;
  logic [1:0]  err_q;

  logic [4:0]  data_q;
  logic [14:0] codeword_q;
  logic [1:0]  err_count_q;
  logic        uncorr_q;
  logic        busy_q;
  logic        done_q;

  // Next-step values shared by the FSM.
  logic [3:0]  bit_idx;
  logic [9:0]  syn_d;       // syndrome after shifting in one received bit
  logic [9:0]  trap_syn_d;  // syndrome after one cyclic rotation (times x)
  logic [3:0]  wt;
  logic        trap_hit;
  logic [14:0] w_fix;
  logic [14:0] w_rot_d;
  logic        cnt_last;

  // NOTE: every signal gets a value at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    bit_idx    = 4'd14 - cnt_q;
    syn_d      = {s_q[8:0], w_q[bit_idx]} ^ (s_q[9] ? G : 10'h000);
    trap_syn_d = {s_q[8:0], 1'b0} ^ (s_q[9] ? G : 10'h000);
    wt         = popcount10(s_q);
    // Only the first qualifying rotation corrects; later ones would
    // re-apply an already removed pattern.
    trap_hit   = !trapped_q && (wt <= TRAP_WT_L);
    w_fix      = trap_hit ? (w_q ^ {5'b00000, s_q}) : w_q;
    w_rot_d    = {w_fix[13:0], w_fix[14]};
    cnt_last   = (cnt_q == 4'd14);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      s_q         <= '0;
      w_q         <= '0;
      cnt_q       <= '0;
      trapped_q   <= 1'b0;
      err_q       <= '0;
      data_q      <= '0;
      codeword_q  <= '0;
      err_count_q <= '0;
      uncorr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            w_q       <= bus.rx_word;
            s_q       <= '0;
            cnt_q     <= '0;
            trapped_q <= 1'b0;
            err_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_SYN;
          end
        end

        S_SYN: begin
          s_q <= syn_d;
          if (cnt_last) begin
            cnt_q <= '0;
`ifdef BCH_DEC_EARLY_EXIT_EN
            if (syn_d == 10'h000) begin
              // Clean word: nothing to trap, report zero errors.
              trapped_q <= 1'b1;
              err_q     <= '0;
              state_q   <= S_DONE;
            end else begin
              state_q   <= S_TRAP;
            end
`else
            state_q <= S_TRAP;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_TRAP: begin
          s_q <= trap_syn_d;
          w_q <= w_rot_d;
          if (trap_hit) begin
            trapped_q <= 1'b1;
            err_q     <= wt[1:0];
          end
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_DONE: begin
          // Untrapped words were never modified, so w is the raw word and
          // err_q is still zero.
          codeword_q  <= w_q;
          data_q      <= w_q[14:10];
          err_count_q <= err_q;
          uncorr_q    <= ~trapped_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out      = data_q;
  assign bus.codeword_out  = codeword_q;
  assign bus.err_count     = err_count_q;
  assign bus.uncorrectable = uncorr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: doc/bch_decoder_15_5.md
Name: bch_decoder_15_5

Overview:
- Downstream companion of the BCH(15,5) encoder. Takes one received 15-bit word (5 data MSBs followed by 10 parity bits) per start pulse.
- Computes the syndrome serially against g(x) = x^10+x^8+x^5+x^4+x^2+x+1, then corrects errors by cyclic error trapping.
- Returns the corrected data, the corrected codeword, an error count and an uncorrectable flag.
- Sits between the receive/deserialise path and the data consumer.

Parameters:
- TRAP_WT, 3, maximum syndrome weight accepted as a trapped error pattern; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request decode of rx_word; sampled only in IDLE.
- rx_word  input  15  received word; bit 14 = coefficient of x^14; [14:10] data, [9:0] parity.
- data_out  output  5  corrected data (raw rx_word[14:10] if uncorrectable).
- codeword_out  output  15  corrected codeword (raw word if uncorrectable).
- err_count  output  2  number of bits corrected, 0..3.
- uncorrectable  output  1  no pattern trapped and syndrome nonzero.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; outputs valid from this cycle on.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal syndrome s[9:0], word w[14:0], counters and trapped flag all 0.
- Code definition: codeword = d(x)*x^10 + (d(x)*x^10 mod g). Low-order taps of g: G = 10'h137.
- States: IDLE -> SYN -> TRAP -> DONE -> IDLE.
- IDLE, start=1:
  - latch w <= rx_word; s <= 0; cnt <= 0; busy <= 1.
  - start while busy is ignored, with no queueing.
- SYN, 15 cycles, MSB first:
  - s <= {s[8:0], w[14-cnt]} ^ (s[9] ? G : 0).
  - After the 15th cycle s = r(x) mod g. Go to TRAP with cnt <= 0.
- TRAP, exactly 15 cycles, i = 0..14:
  - If trapped=0 and popcount(s) <= TRAP_WT: w_next = rot(w ^ {5'b0, s}); trapped <= 1; err_count <= popcount(s).
  - Otherwise w_next = rot(w).
  - rot(x) = {x[13:0], x[14]}.
  - s <= {s[8:0], 1'b0} ^ (s[9] ? G : 0).
  - Correction is applied only at the first trap.
  - After 15 rotations w is back in its original alignment.
- DONE, 1 cycle:
  - codeword_out <= w; data_out <= w[14:10].
  - uncorrectable <= ~trapped.
  - When uncorrectable, w is unmodified and err_count is 0.
  - done=1 for this cycle; busy=0 in this cycle. Return to IDLE.
- Outputs hold their values until the next DONE. done is a pulse only.
- Latency: start sampled at edge k -> done high in the cycle after edge k+31 (1 load + 15 SYN + 15 TRAP).
- Zero syndrome traps at i=0 with err_count=0.
- Guarantees:
  - All patterns of <=2 errors are corrected.
  - 3-error patterns with >=5 consecutive error-free positions (cyclic) are corrected.
  - Any other 3-error pattern is flagged uncorrectable and is never miscorrected (d_min=7).
- rst_n low mid-decode: immediate abort to IDLE, all outputs 0; no done pulse.

Optional Feature:
- Macro BCH_DEC_EARLY_EXIT_EN.
- Defined: if s==0 after SYN, skip TRAP and go straight to DONE with err_count=0, uncorrectable=0. Latency drops to done after edge k+16. Nonzero syndromes are unchanged (k+31).
- Undefined: fixed 31-cycle latency for every word.

Test Plan:
- Clean word: rx_word=15'h429B (data 5'b10000) -> done at k+31 (k+16 with BCH_DEC_EARLY_EXIT_EN); data_out=5'b10000, codeword_out=15'h429B, err_count=0, uncorrectable=0.
- 2 errors: rx_word=15'h029A (15'h429B with bits 14 and 0 flipped) -> codeword_out=15'h429B, data_out=5'b10000, err_count=2, uncorrectable=0.
- 3 clustered errors: rx_word=15'h0539 (15'h0537 with bits 3:1 flipped) -> codeword_out=15'h0537, data_out=5'b00001, err_count=3, uncorrectable=0.
- 3 spread errors: rx_word=15'h0421 (all-zero codeword with bits 10, 5 and 0 flipped) -> uncorrectable=1, codeword_out=15'h0421, data_out=5'b00001, err_count=0.
- Start while busy: second start pulse at k+5 with rx_word=15'h7FFF -> ignored; the first decode completes with its own result and exactly one done pulse.
- Reset mid-decode: rst_n=0 at k+20 -> all outputs 0 immediately, busy=0, no done; a fresh start with 15'h0537 then decodes correctly.
